// File: rtl/parallel_serial_tx_pkg.sv
// Shared constants, FSM encoding and helpers for the parallel-to-serial transmitter.
package parallel_serial_tx_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned SLOT_LEN    = 8;
    localparam int unsigned BIT_CNT_W   = $clog2(SLOT_LEN);
    localparam int unsigned COMMA_CNT_W = 4;

    // Idle/alignment character the receiver locks onto.
    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

    // True on the bit position whose following edge starts a new slot.
    function automatic logic slot_load(input logic [BIT_CNT_W-1:0] bit_cnt);
        return bit_cnt == BIT_CNT_W'(SLOT_LEN - 1);
    endfunction

endpackage

// File: rtl/parallel_serial_tx_if.sv
// Byte-in / bit-out bus of the transmitter.
//   data_in, valid_in : byte offered by the upstream source
//   ready_out         : transmitter accepts data_in this cycle
//   data_out          : serial stream, MSB of each slot first
//   frame_out         : marks the MSB bit of each slot
//   sync_done         : comma preamble has been sent
interface parallel_serial_tx_if;
    import parallel_serial_tx_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              data_out;
    logic              frame_out;
    logic              sync_done;

    // Source / observer side.
    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  frame_out,
        input  sync_done
    );

    // Transmitter side.
    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output frame_out,
        output sync_done
    );
endinterface

// File: rtl/parallel_serial_tx_fifo.sv
// tx_byte_fifo: small synchronous byte FIFO in front of the serializer.
//   clk_32f, reset : bit clock, synchronous active-high reset (pointers only)
//   push, din      : write din when not full
//   pop, dout      : dout shows the head; pop advances it when not empty
//   count          : number of stored entries (0..DEPTH)
//   full, empty    : occupancy flags
module tx_byte_fifo
    import parallel_serial_tx_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; only the pointers define contents.
    always_ff @(posedge clk_32f) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: buffers bytes from a valid/ready source and serializes them
// MSB first into 8-bit slots on clk_32f. Empty slots carry the comma 0xBC, and
// after reset MIN_COMMAS commas are forced before any data so the receiver locks.
//   clk_32f : bit clock
//   reset   : synchronous, active-high
//   bus     : byte handshake in, serial bit/frame/sync out (slave side)
module parallel_serial_tx
    import parallel_serial_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MIN_COMMAS = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    parallel_serial_tx_if.slave  bus
);

    localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e              state_q;
    tx_state_e              state_d;
    logic [COMMA_CNT_W-1:0] comma_cnt_q;
    logic [COMMA_CNT_W-1:0] comma_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BYTE_W-2:0]      sr_q;
    logic                   data_out_q;
    logic                   frame_out_q;
    logic                   sync_done_q;

    logic                   load;
    logic [BYTE_W-1:0]      next_byte;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [BYTE_W-1:0]      fifo_dout;
    logic [FIFO_CW-1:0]     fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   ready_c;

    // Accept only in RUN with room; full at this edge blocks until the next cycle.
    assign ready_c   = !reset && (state_q == RUN) && (fifo_count != FIFO_CW'(FIFO_DEPTH));
    assign fifo_push = bus.valid_in && ready_c;
    assign load      = slot_load(bit_cnt_q);

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_32f (clk_32f),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (bus.data_in),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state and slot byte selection; a push on a load edge is not visible
    // to this pop, so a byte pushed into an empty FIFO waits one slot.
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        fifo_pop    = 1'b0;
        next_byte   = COMMA;
        if (load) begin
            unique case (state_q)
                SYNC: begin
                    comma_cnt_d = comma_cnt_q + COMMA_CNT_W'(1);
                    if (comma_cnt_q == COMMA_CNT_W'(MIN_COMMAS - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        next_byte = fifo_dout;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // State register, bit counter and serializer; reset drops any in-flight bits.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= SYNC;
            comma_cnt_q <= '0;
            bit_cnt_q   <= BIT_CNT_W'(SLOT_LEN - 1);
            sr_q        <= '0;
            data_out_q  <= 1'b0;
            frame_out_q <= 1'b0;
            sync_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            bit_cnt_q   <= bit_cnt_q + BIT_CNT_W'(1);
            sync_done_q <= state_d == RUN;
            if (load) begin
                data_out_q  <= next_byte[BYTE_W-1];
                sr_q        <= next_byte[BYTE_W-2:0];
                frame_out_q <= 1'b1;
            end else begin
                data_out_q  <= sr_q[BYTE_W-2];
                sr_q        <= {sr_q[BYTE_W-3:0], 1'b0};
                frame_out_q <= 1'b0;
            end
        end
    end

    // The occupancy count and the full flag must always agree.
    a_full_consistent: assert property (@(posedge clk_32f) disable iff (reset)
        fifo_full == (fifo_count == FIFO_CW'(FIFO_DEPTH)));

    assign bus.ready_out = ready_c;
    assign bus.data_out  = data_out_q;
    assign bus.frame_out = frame_out_q;
    assign bus.sync_done = sync_done_q;

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Bench for parallel_serial_tx: slot-level reference model, frame-aligned
// deserializer of the DUT stream, table-driven preamble check, directed corner
// cases and a randomized run.
module tb_parallel_serial_tx;
    import parallel_serial_tx_pkg::*;

    localparam int DEPTH = 4;
    localparam int MINC  = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    parallel_serial_tx_if bus ();

    parallel_serial_tx #(
        .FIFO_DEPTH (DEPTH),
        .MIN_COMMAS (MINC)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int errors = 0;
    int checks = 0;

    // Reference model: edge index within the run, slots started, queue, slot bytes.
    int         m_cyc   = 0;
    int         m_slots = 0;
    logic [7:0] m_cur   = 8'h00;
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];

    // Deserializer of the DUT output, aligned on frame_out.
    logic [7:0] d_byte  = 8'h00;
    int         d_cnt   = 0;
    int         frames  = 0;
    logic [7:0] d_bytes[$];

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       exp_data;
        logic       exp_frame;
        logic       exp_sync;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_slot(input string name, input int idx, input logic [7:0] exp);
        if (idx >= 0 && idx < d_bytes.size()) chk(name, 32'(d_bytes[idx]), 32'(exp));
        else chk(name, 32'hFFFF_FFFF, 32'(exp));
    endtask

    // One clk_32f cycle: drive, check ready, advance model and DUT, check outputs.
    task automatic step(input logic rst, input logic v, input logic [7:0] d, output logic pushed);
        logic exp_ready;
        logic e_data;
        logic e_frame;
        logic e_sync;
        reset        = rst;
        bus.valid_in = v;
        bus.data_in  = d;
        #1;
        exp_ready = !rst && (m_slots >= MINC) && (m_q.size() < DEPTH);
        chk("ready_out", 32'(bus.ready_out), 32'(exp_ready));
        pushed = v && exp_ready;
        @(posedge clk_32f);
        if (rst) begin
            m_q.delete();
            m_sent.delete();
            m_cyc   = 0;
            m_slots = 0;
            m_cur   = 8'h00;
            e_data  = 1'b0;
            e_frame = 1'b0;
            e_sync  = 1'b0;
        end else begin
            if (m_cyc % 8 == 0) begin
                if (m_slots >= MINC && m_q.size() != 0) m_cur = m_q.pop_front();
                else m_cur = COMMA;
                m_sent.push_back(m_cur);
                m_slots++;
            end
            if (pushed) m_q.push_back(d);
            e_data  = m_cur[7 - (m_cyc % 8)];
            e_frame = (m_cyc % 8 == 0);
            e_sync  = (m_slots >= MINC);
            m_cyc++;
        end
        #1;
        chk("data_out", 32'(bus.data_out), 32'(e_data));
        chk("frame_out", 32'(bus.frame_out), 32'(e_frame));
        chk("sync_done", 32'(bus.sync_done), 32'(e_sync));
        if (rst) begin
            d_cnt  = 0;
            frames = 0;
            d_bytes.delete();
        end else if (bus.frame_out) begin
            d_byte = {7'b0, bus.data_out};
            d_cnt  = 1;
            frames++;
        end else if (d_cnt > 0 && d_cnt < 8) begin
            d_byte = {d_byte[6:0], bus.data_out};
            d_cnt++;
        end
        if (d_cnt == 8) begin
            d_bytes.push_back(d_byte);
            d_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        logic p;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, p);
    endtask

    // Idle until the next edge has the requested position within the slot.
    task automatic align(input int phase);
        logic p;
        for (int k = 0; k < 8 && (m_cyc % 8) != phase; k++) step(1'b0, 1'b0, 8'h00, p);
        chk("align", 32'(m_cyc % 8), 32'(phase));
    endtask

    initial begin
        vec_t       tbl[35];
        logic [7:0] comma_bits;
        logic [7:0] src[6];
        logic [7:0] got[$];
        logic       p;
        int         n0;
        int         acc;
        int         first_drop;

        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        // Test 1: reset then preamble of commas, bit pattern 1,0,1,1,1,1,0,0.
        comma_bits = 8'b1011_1100;
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 32; i++)
            tbl[i+3] = '{1'b0, 1'b0, 8'h00, comma_bits[7 - (i % 8)], (i % 8 == 0), (i >= 24)};
        for (int i = 0; i < 35; i++) begin
            step(tbl[i].rst, tbl[i].valid, tbl[i].data, p);
            chk("tbl_data", 32'(bus.data_out), 32'(tbl[i].exp_data));
            chk("tbl_frame", 32'(bus.frame_out), 32'(tbl[i].exp_frame));
            chk("tbl_sync", 32'(bus.sync_done), 32'(tbl[i].exp_sync));
        end
        for (int i = 0; i < 4; i++) chk_slot("preamble", i, 8'hBC);

        // Test 2: mid-slot push of 0xA5 goes out in the next slot, then commas.
        idle(3);
        n0 = frames;
        step(1'b0, 1'b1, 8'hA5, p);
        chk("a5_accepted", 32'(p), 32'd1);
        idle(24);
        chk_slot("a5_slot", n0, 8'hA5);
        chk_slot("a5_after", n0 + 1, 8'hBC);

        // Test 3: six bytes with valid held; ready drops after four accepted.
        src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        align(1);
        n0 = frames;
        acc = 0;
        first_drop = -1;
        for (int k = 0; k < 60 && acc < 6; k++) begin
            step(1'b0, 1'b1, src[acc], p);
            if (p) acc++;
            else if (first_drop < 0) first_drop = acc;
        end
        chk("burst_accepted", 32'(acc), 32'd6);
        chk("full_after", 32'(first_drop), 32'd4);
        idle(56);
        for (int i = 0; i < 6; i++) chk_slot("burst_slot", n0 + i, src[i]);
        chk_slot("burst_tail", n0 + 6, 8'hBC);

        // Test 4: push exactly on a load edge with the FIFO empty.
        align(0);
        n0 = frames;
        step(1'b0, 1'b1, 8'h3C, p);
        chk("3c_accepted", 32'(p), 32'd1);
        idle(16);
        chk_slot("load_edge_comma", n0, 8'hBC);
        chk_slot("load_edge_byte", n0 + 1, 8'h3C);

        // Test 5: reset at bit 3 of 0x5A with two bytes queued.
        align(1);
        step(1'b0, 1'b1, 8'h5A, p);
        step(1'b0, 1'b1, 8'h11, p);
        step(1'b0, 1'b1, 8'h22, p);
        idle(8);
        chk("pre_rst_frame_pos", 32'(m_cyc % 8), 32'd4);
        step(1'b1, 1'b0, 8'h00, p);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_sync", 32'(bus.sync_done), 32'd0);
        idle(48);
        for (int i = 0; i < 6; i++) chk_slot("post_rst_comma", i, 8'hBC);

        // Test 6: loopback-style decode of 0x11,0x22,0x33; commas are not data.
        align(1);
        n0 = frames;
        step(1'b0, 1'b1, 8'h11, p);
        step(1'b0, 1'b1, 8'h22, p);
        step(1'b0, 1'b1, 8'h33, p);
        idle(40);
        got.delete();
        for (int i = n0; i < d_bytes.size(); i++)
            if (d_bytes[i] != COMMA) got.push_back(d_bytes[i]);
        chk("rx_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("rx_0", 32'(got[0]), 32'h11);
            chk("rx_1", 32'(got[1]), 32'h22);
            chk("rx_2", 32'(got[2]), 32'h33);
        end

        // Test 7: random traffic with occasional resets, stream vs model.
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
                 8'($urandom), p);
        end
        align(0);
        chk("rand_slots", 32'(d_bytes.size()), 32'(m_sent.size()));
        for (int i = 0; i < d_bytes.size() && i < m_sent.size(); i++)
            chk("rand_slot", 32'(d_bytes[i]), 32'(m_sent[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
